// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion
// and a single block in flight, valid/ready handshake on both sides.
module aes128_enc_iter #(
  parameter int NR      = 10,
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_enc_iter: NR=%0d unsupported, only 10 rounds", NR);
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] t, n0, n1, n2, n3;
    // SubWord(RotWord(w3)) ^ Rcon
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(rnd), 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Byte (r,c) lives at index r+4c; row r rotates left by r columns.
  function automatic logic [127:0] shift_row(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] state, rk;
  logic [3:0]   round;
  logic [127:0] rk_next, sr, round_out;

  always_comb begin
    rk_next   = key_exp(rk, round);
    sr        = shift_row(sub_bytes(state));
    round_out = ((round == LAST_ROUND) ? sr : mix_columns(sr)) ^ rk_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= S_IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt  = fsm;
    in_ready = 1'b0;
    case (fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = S_ROUND;
      end
      S_ROUND: if (round == LAST_ROUND) fsm_nxt = S_DONE;
      S_DONE:  if (out_ready) fsm_nxt = S_IDLE;
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= '0;
      rk         <= '0;
      round      <= '0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            state <= plaintext ^ key;
            rk    <= key;
            round <= 4'd1;
          end
        end
        S_ROUND: begin
          state <= round_out;
          rk    <= rk_next;
          round <= round + 4'd1;
          if (round == LAST_ROUND) begin
            ciphertext <= round_out;
            out_valid  <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round     <= '0;
            if (ZEROIZE) begin
              state <= '0;
              rk    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Bench for aes128_enc_iter: known-answer table, latency, backpressure, back-to-back,
// mid-block reset and key/state zeroization (ZEROIZE=1 and ZEROIZE=0 instances).
module tb_aes128_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [127:0] plaintext, key;
  logic         in_ready, out_valid, in_ready_nz, out_valid_nz;
  logic [127:0] ciphertext, ciphertext_nz;

  always #5 clk = ~clk;

  aes128_enc_iter #(.NR(10), .ZEROIZE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext)
  );

  aes128_enc_iter #(.NR(10), .ZEROIZE(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nz),
    .plaintext(plaintext), .key(key), .out_valid(out_valid_nz), .out_ready(out_ready),
    .ciphertext(ciphertext_nz)
  );

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] rk10;
  } vec_t;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           hs_cyc = 0;
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  vec_t         vecs[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on every output handshake seen at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got ciphertext %h expected no output", ciphertext);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("ciphertext", ciphertext, mon_exp);
        chk("ciphertext_nz", ciphertext_nz, mon_exp);
        hs_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] c,
                      input bit hold_valid);
    bit seen;
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    seen      = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 128'(seen), 128'd1);
    if (seen) begin
      exp_q.push_back(c);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("out_valid_timeout", 128'(seen), 128'd1);
    if (seen) lat = cyc - acc_cyc - 1;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;
    vecs[0] = '{C1_PT, C1_KEY, C1_CT, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[1] = '{B_PT, B_KEY, B_CT, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{128'h0, 128'h0, Z_CT, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0;

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_ciphertext", ciphertext, 128'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_state", dut.state, 128'h0);
    chk("rst_rk", dut.rk, 128'h0);
    chk("rst_round", 128'(dut.round), 128'd0);

    // Known-answer table with latency and zeroization checks
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].pt, vecs[i].key, vecs[i].ct, 1'b0);
      wait_out(lat);
      chk("latency", 128'(lat), 128'd10);
      @(negedge clk);
      chk("zeroize_state", dut.state, 128'h0);
      chk("zeroize_rk", dut.rk, 128'h0);
      chk("retain_state", dut_nz.state, vecs[i].ct);
      chk("retain_rk", dut_nz.rk, vecs[i].rk10);
      chk("ct_kept", ciphertext, vecs[i].ct);
      chk("ct_kept_nz", ciphertext_nz, vecs[i].ct);
      chk("post_in_ready", 128'(in_ready), 128'd1);
      chk("post_out_valid", 128'(out_valid), 128'd0);
    end

    // Round-1 internal state (FIPS-197 Appendix B)
    send(B_PT, B_KEY, B_CT, 1'b0);
    chk("ark0_state", dut.state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    @(posedge clk); #1;
    chk("r1_state", dut.state, 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("r1_rk", dut.rk, 128'ha0fafe1788542cb123a339392a6c7605);
    wait_out(lat);
    chk("latency_b", 128'(lat), 128'd10);
    @(negedge clk);

    // Backpressure: hold out_ready low for 20 clocks with new input offered
    out_ready = 1'b0;
    send('0, '0, Z_CT, 1'b0);
    wait_out(lat);
    plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid), 128'd1);
      chk("hold_ciphertext", ciphertext, Z_CT);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready), 128'd1);
    chk("release_out_valid", 128'(out_valid), 128'd0);
    chk("release_queue_empty", 128'(exp_q.size()), 128'd0);

    // Back-to-back with in_valid held and inputs changing mid-block
    out_ready = 1'b1;
    send(C1_PT, C1_KEY, C1_CT, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    plaintext = B_PT; key = B_KEY;
    send(B_PT, B_KEY, B_CT, 1'b0);
    chk("b2b_gap", 128'(acc_cyc - hs_cyc), 128'd1);
    wait_out(lat);
    chk("b2b_latency", 128'(lat), 128'd10);
    @(negedge clk);

    // Asynchronous reset at round 5 aborts the block
    send(C1_PT, C1_KEY, C1_CT, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_round", 128'(dut.round), 128'd5);
    #2; rst_n = 1'b0; #1;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_ciphertext", ciphertext, 128'h0);
    chk("abort_state", dut.state, 128'h0);
    chk("abort_round", 128'(dut.round), 128'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("abort_no_out_valid", 128'(bad), 128'd0);
    send(C1_PT, C1_KEY, C1_CT, 1'b0);
    wait_out(lat);
    chk("resubmit_latency", 128'(lat), 128'd10);
    @(negedge clk);
    @(negedge clk);
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
